// File: rtl/pic_pkg.sv
// Shared types and the rotating-priority search used by the 8259 interrupt resolver.
package pic_pkg;
  localparam int LEVEL_W = 3;
  localparam int IR_W    = 8;
  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;
  localparam logic [LEVEL_W-1:0] FIXED_LOWEST   = 3'd7;

  typedef struct packed {
    logic               valid;
    logic [LEVEL_W-1:0] level;
  } prio_t;

  // Walk from the lowest-priority level upward so the highest-priority set bit wins.
  function automatic prio_t rotate_prio(input logic [IR_W-1:0] mask,
                                        input logic [LEVEL_W-1:0] lowest);
    prio_t r;
    logic [LEVEL_W-1:0] lvl;
    r = '0;
    for (int i = 0; i < IR_W; i++) begin
      lvl = lowest - LEVEL_W'(i);
      if (mask[lvl]) begin
        r.valid = 1'b1;
        r.level = lvl;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/pic_interrupt_resolver_if.sv
// Control-logic <-> resolver bundle: decoded mode/command strobes in, request and status images out.
interface pic_interrupt_resolver_if
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8
);
  logic               init;
  logic               ltim;
  logic [NUM_IR-1:0]  imr;
  logic               aeoi;
  logic               inta_first;
  logic               inta_last;
  logic               eoi_valid;
  logic               eoi_specific;
  logic [LEVEL_W-1:0] eoi_level;
  logic               rotate_on_eoi;
  logic               int_req;
  logic [LEVEL_W-1:0] vector_level;
  logic [LEVEL_W-1:0] isr_highest;
  logic [NUM_IR-1:0]  irr;
  logic [NUM_IR-1:0]  isr;

  modport master (
    output init, ltim, imr, aeoi, inta_first, inta_last,
           eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
    input  int_req, vector_level, isr_highest, irr, isr
  );

  modport slave (
    input  init, ltim, imr, aeoi, inta_first, inta_last,
           eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
    output int_req, vector_level, isr_highest, irr, isr
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority encoder: highest-priority set bit of mask given lowest_prio.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [IR_W-1:0]    mask,
  input  logic [LEVEL_W-1:0] lowest_prio,
  output prio_t              win
);
  assign win = rotate_prio(mask, lowest_prio);
endmodule

// File: rtl/pic_interrupt_resolver.sv
// 8259 IRR/ISR holding and priority resolution. Define PIC_ROTATE_EN for rotating priority;
// otherwise priority is fixed with IR0 highest.
module pic_interrupt_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] ir_in,
  pic_interrupt_resolver_if.slave ctl
);
  logic [NUM_IR-1:0]  irr_q, isr_q, ir_prev;
  logic [NUM_IR-1:0]  req, ack, eoi_clr, aeoi_clr, irr_nxt, isr_nxt;
  logic [LEVEL_W-1:0] lowest_prio, vector_level_q, isr_highest_q, pending_level;
  logic [LEVEL_W-1:0] req_rank, isr_rank;
  logic               pending_vld, int_req_q, int_req_nxt, aeoi_fire;
  prio_t              req_win, isr_win;

  assign req = irr_q & ~ctl.imr;

  pic_priority_resolver u_req_res (.mask(req),   .lowest_prio(lowest_prio), .win(req_win));
  pic_priority_resolver u_isr_res (.mask(isr_q), .lowest_prio(lowest_prio), .win(isr_win));

  always_comb begin
    ack = '0;
    if (ctl.inta_first && req_win.valid) ack[req_win.level] = 1'b1;
    eoi_clr = '0;
    if (ctl.eoi_valid) begin
      if (ctl.eoi_specific)  eoi_clr[ctl.eoi_level] = 1'b1;
      else if (isr_win.valid) eoi_clr[isr_win.level] = 1'b1;
    end
    aeoi_fire = ctl.inta_last && ctl.aeoi && pending_vld;
    aeoi_clr  = '0;
    if (aeoi_fire) aeoi_clr[pending_level] = 1'b1;
    // Set after clear: an acknowledge on a bit being EOI'd in the same cycle keeps it in service.
    isr_nxt = (isr_q & ~(eoi_clr | aeoi_clr)) | ack;
    // Edge mode holds a captured request only while the line stays high.
    irr_nxt = ctl.ltim ? (ir_in & ~ack) : (ir_in & (irr_q | ~ir_prev) & ~ack);
    // Rank 0 is the highest priority under the current rotation.
    req_rank    = req_win.level - lowest_prio - LEVEL_W'(1);
    isr_rank    = isr_win.level - lowest_prio - LEVEL_W'(1);
    int_req_nxt = req_win.valid && (!isr_win.valid || (req_rank < isr_rank));
  end

`ifdef PIC_ROTATE_EN
  logic [LEVEL_W-1:0] eoi_lvl;
  assign eoi_lvl = ctl.eoi_specific ? ctl.eoi_level : isr_win.level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 lowest_prio <= FIXED_LOWEST;
    else if (ctl.init)                            lowest_prio <= FIXED_LOWEST;
    else if (ctl.rotate_on_eoi) begin
      if (ctl.eoi_valid && (|eoi_clr))            lowest_prio <= eoi_lvl;
      else if (aeoi_fire)                         lowest_prio <= pending_level;
    end
  end
`else
  assign lowest_prio = FIXED_LOWEST;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irr_q          <= '0;
      isr_q          <= '0;
      ir_prev        <= '1;
      vector_level_q <= '0;
      isr_highest_q  <= '0;
      int_req_q      <= 1'b0;
      pending_level  <= '0;
      pending_vld    <= 1'b0;
    end else if (ctl.init) begin
      irr_q          <= '0;
      isr_q          <= '0;
      ir_prev        <= '1;
      vector_level_q <= '0;
      isr_highest_q  <= '0;
      int_req_q      <= 1'b0;
      pending_level  <= '0;
      pending_vld    <= 1'b0;
    end else begin
      ir_prev       <= ir_in;
      irr_q         <= irr_nxt;
      isr_q         <= isr_nxt;
      isr_highest_q <= isr_win.level;
      int_req_q     <= ctl.inta_first ? 1'b0 : int_req_nxt;
      if (ctl.inta_first) begin
        vector_level_q <= req_win.valid ? req_win.level : SPURIOUS_LEVEL;
        pending_level  <= req_win.level;
        pending_vld    <= req_win.valid;
      end else if (ctl.inta_last) begin
        pending_vld    <= 1'b0;
      end
    end
  end

  assign ctl.int_req      = int_req_q;
  assign ctl.vector_level = vector_level_q;
  assign ctl.isr_highest  = isr_highest_q;
  assign ctl.irr          = irr_q;
  assign ctl.isr          = isr_q;
endmodule

// File: doc/pic_interrupt_resolver.md
# pic_interrupt_resolver

- Sits between the IR pins and the 8259 control logic.
- Holds the interrupt request register (IRR) and the in-service register (ISR), and resolves priority.
- Uses the trigger mode, mask, acknowledge strobes and EOI commands decoded by the control logic.
- Returns to the control logic the interrupt request flag, the winning level for the vector, and the IRR/ISR images for status reads.

## Interface
Parameters:
- NUM_IR, 8: number of interrupt request lines (fixed 8; encodings are 3-bit).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init  in  1  one-cycle pulse on an ICW1 write; synchronously re-initialises the block.
- ir_in  in  8  raw IR0..IR7 request lines.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered.
- imr  in  8  interrupt mask (OCW1); 1 = masked.
- aeoi  in  1  automatic-EOI mode.
- inta_first  in  1  one-cycle pulse for the first INTA.
- inta_last  in  1  one-cycle pulse at the end of the final INTA.
- eoi_valid  in  1  one-cycle pulse on an OCW2 EOI command.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific EOI.
- eoi_level  in  3  level for specific EOI.
- rotate_on_eoi  in  1  rotate priority on this EOI or AEOI.
- int_req  out  1  registered interrupt request to the CPU path.
- vector_level  out  3  level latched at inta_first, used as vector bits [2:0].
- isr_highest  out  3  highest-priority level currently in service.
- irr  out  8  IRR image.
- isr  out  8  ISR image.

## Operation
State:
- irr, isr, ir_prev, lowest_prio (3 bits), vector_level, int_req.
- pending_level (3 bits) records the level being acknowledged, for AEOI.

Request capture:
- Edge mode: irr[i] sets when ir_in[i]=1 and ir_prev[i]=0. It stays set until acknowledged, or until ir_in[i] is sampled low while still unacknowledged.
- Level mode: irr[i] follows ir_in[i] each cycle.
- Masking does not block capture. It only excludes the bit from arbitration.

Priority:
- Priority order starts at level lowest_prio+1 (mod 8) and descends.
- Reset value of lowest_prio is 7, so IR0 is highest.
- req = irr & ~imr. int_req is 1 next cycle iff req is non-zero and its top level outranks every ISR bit (fully nested).

inta_first:
- With a request: vector_level = winning level, isr bit set, irr bit cleared in both modes.
- With no request (spurious): vector_level = 7, ISR unchanged.
- int_req drops the following cycle.

inta_last with aeoi=1:
- Clears the isr bit latched at inta_first.
- If rotate_on_eoi=1, lowest_prio = that level.

EOI:
- Non-specific: clears the highest-priority ISR bit.
- Specific: clears isr[eoi_level].
- Rotation: lowest_prio = the cleared level. A non-specific EOI with ISR empty does nothing.

Simultaneous events:
- EOI or AEOI clear and inta_first set in the same cycle: both apply. If they hit the same bit, set wins.
- Arbitration always uses pre-edge ISR.

Other conditions:
- init clears irr, isr and vector_level, sets lowest_prio=7, sets ir_prev=8'hFF and int_req=0.
- Asynchronous reset gives the same values. A line high at reset or init therefore never produces an edge.

## Timing
- All outputs are registered. Reset values: int_req=0, vector_level=0, isr_highest=0, irr=0, isr=0.
- Latency: ir_in rising, sampled at edge N → irr visible after N → int_req after N+1.
- isr/irr/vector_level update at the same edge that samples inta_first. isr_highest follows one cycle later.
- inta_first and inta_last must be at least 1 cycle apart. Pulses longer than one cycle are treated as repeated events.
- Reset asserted mid-acknowledge aborts the cycle; pending AEOI is discarded.

## Configuration
- PIC_ROTATE_EN defined: rotate_on_eoi is honoured and lowest_prio updates as described.
- PIC_ROTATE_EN undefined: lowest_prio is a constant 7 (fixed priority, IR0 highest) and rotate_on_eoi is ignored.

## Structure
- Shared package pic_pkg holds: LEVEL_W=3, the spurious level constant SPURIOUS_LEVEL=3'd7, and the rotate-priority function (mask, lowest_prio → winning level and valid).
- One sub-module: pic_priority_resolver. It is combinational, instantiated twice: once on req, once on isr.

## Test plan
- Edge mode, imr=0, pulse ir_in[3] high → irr=8'h08 next cycle, int_req=1 one cycle later. Then inta_first → vector_level=3, isr=8'h08, irr=0, int_req=0.
- Level mode: hold ir_in=8'h24 with isr=8'h04 → int_req stays 0 (IR5 lower than in-service IR2). Non-specific EOI → isr=0, int_req=1, winner 2.
- Spurious: raise ir_in[6], drop it before inta_first → vector_level=7, isr=0.
- AEOI with rotation (PIC_ROTATE_EN): acknowledge IR1, then inta_last → isr=0, lowest_prio=1. IR1 and IR2 both pending → winner 2.
- Specific EOI eoi_level=4 in the same cycle as inta_first on IR4 with isr[4] already set → isr[4] remains 1.
- ir_in=8'hFF held through reset release → irr stays 0. init mid-service → irr=isr=0, int_req=0.
